appliance_ctrl_hub: RTL and testbench

Parametrised successor to the single-shot appliance top level. Controls N_DEV identical appliance channels (setpoint, fan level, run timer) through one valid/ready command port. Each channel has a countdown timer FSM driven by a shared prescaled minute tick, and a registered Celsius/Fahrenheit display output. Sits between the front-panel command decoder and the per-appliance actuator/display logic.

---
 rtl/hub_pkg.sv | 42 ++++
 rtl/hub_channel.sv | 134 +++++++++++++
 rtl/appliance_ctrl_hub.sv | 114 +++++++++++
 tb/tb_appliance_ctrl_hub.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// Shared definitions for the appliance control hub: command field codes,
// control bit positions, channel state encoding and Celsius->Fahrenheit
// display helper.
// Optional feature macro: HUB_PAUSE_EN (adds the PAUSE channel state).
package hub_pkg;

  localparam int unsigned TEMP_W = 7;  // displayed temperature width
  localparam int unsigned SP_W   = 5;  // stored setpoint width (max 31 C)

  localparam logic [1:0] FIELD_SETPOINT = 2'd0;
  localparam logic [1:0] FIELD_FAN      = 2'd1;
  localparam logic [1:0] FIELD_TIMER    = 2'd2;
  localparam logic [1:0] FIELD_CTRL     = 2'd3;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_STOP  = 1;
`ifdef HUB_PAUSE_EN
  localparam int unsigned CTRL_PAUSE = 2;
`endif

  localparam int unsigned C2F_MUL = 9;
  localparam int unsigned C2F_DIV = 5;
  localparam int unsigned C2F_OFF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
`ifdef HUB_PAUSE_EN
    ,
    ST_PAUSE = 2'd3
`endif
  } ch_state_t;

  // F = C*9/5 + 32, truncated; 31 C -> 87 F fits the 7-bit display
  function automatic logic [TEMP_W-1:0] c_to_f(input logic [SP_W-1:0] c);
    logic [8:0] scaled;
    scaled = 9'(c) * 9'(C2F_MUL) / 9'(C2F_DIV) + 9'(C2F_OFF);
    return TEMP_W'(scaled);
  endfunction

endpackage

// File: rtl/hub_channel.sv
// One appliance channel: setpoint/fan/timer registers, countdown FSM
// (IDLE/RUN/DONE, plus PAUSE when HUB_PAUSE_EN is defined) and the
// registered Celsius/Fahrenheit display.
// Ports: clk, rst (async, active-high); tick (shared prescaler strobe);
// cmd_en/cmd_field/cmd_data (command applied this cycle); temp_unit;
// temp_out, fan_out, remain_out, run_out, done_out (registered);
// start_fail_c (combinational: a start accepted now would find the
// channel idle with a zero timer at the apply edge).
module hub_channel
  import hub_pkg::*;
#(
  parameter int unsigned VAL_W    = 5,
  parameter int unsigned TEMP_MIN = 16,
  parameter int unsigned TEMP_MAX = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              cmd_en,
  input  logic [1:0]        cmd_field,
  input  logic [VAL_W-1:0]  cmd_data,
  input  logic              temp_unit,
  output logic [TEMP_W-1:0] temp_out,
  output logic [1:0]        fan_out,
  output logic [VAL_W-1:0]  remain_out,
  output logic              run_out,
  output logic              done_out,
  output logic              start_fail_c
);

  ch_state_t         state;
  logic [SP_W-1:0]   setpoint;
  logic [SP_W-1:0]   sp_clamp;
  logic              is_ctrl;
  logic              is_load;
  logic              do_stop;
  logic              do_start;
`ifdef HUB_PAUSE_EN
  logic              do_pause;
`endif

  assign is_ctrl  = cmd_en && (cmd_field == FIELD_CTRL);
  assign is_load  = cmd_en && (cmd_field == FIELD_TIMER);
  assign do_stop  = is_ctrl && cmd_data[CTRL_STOP];
  assign do_start = is_ctrl && cmd_data[CTRL_START] && !cmd_data[CTRL_STOP];
`ifdef HUB_PAUSE_EN
  assign do_pause = is_ctrl && cmd_data[CTRL_PAUSE] && !cmd_data[CTRL_STOP];
`endif

  // Commands are never applied in the accept cycle, so only a tick can move
  // the channel between accept and apply.
  assign start_fail_c = (((state == ST_IDLE) || (state == ST_DONE)) && (remain_out == '0)) ||
                        ((state == ST_RUN) && tick && (remain_out == VAL_W'(1)));

  // Setpoint write value clamped into the legal Celsius range
  always_comb begin
    sp_clamp = SP_W'(TEMP_MIN);
    if (cmd_data > VAL_W'(TEMP_MAX)) begin
      sp_clamp = SP_W'(TEMP_MAX);
    end else if (cmd_data >= VAL_W'(TEMP_MIN)) begin
      sp_clamp = SP_W'(cmd_data);
    end
  end

  // Channel registers and countdown FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      setpoint   <= SP_W'(TEMP_MIN);
      fan_out    <= 2'd0;
      remain_out <= '0;
      run_out    <= 1'b0;
      done_out   <= 1'b0;
      temp_out   <= TEMP_W'(TEMP_MIN);
    end else begin
      done_out <= 1'b0;
      temp_out <= temp_unit ? c_to_f(setpoint) : TEMP_W'(setpoint);

      if (cmd_en && (cmd_field == FIELD_SETPOINT)) setpoint <= sp_clamp;
      if (cmd_en && (cmd_field == FIELD_FAN))      fan_out  <= cmd_data[1:0];
      if (is_load)                                 remain_out <= cmd_data;

      unique case (state)
        ST_IDLE: begin
          if (do_start && (remain_out != '0)) begin
            state   <= ST_RUN;
            run_out <= 1'b1;
          end
        end
        ST_RUN: begin
          if (do_stop || (is_load && (cmd_data == '0))) begin
            state   <= ST_IDLE;
            run_out <= 1'b0;
`ifdef HUB_PAUSE_EN
          end else if (do_pause) begin
            state   <= ST_PAUSE;
            run_out <= 1'b0;
`endif
          end else if (!cmd_en && tick) begin
            // any command to this channel pre-empts the decrement
            remain_out <= remain_out - VAL_W'(1);
            if (remain_out == VAL_W'(1)) begin
              state    <= ST_DONE;
              run_out  <= 1'b0;
              done_out <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
`ifdef HUB_PAUSE_EN
        ST_PAUSE: begin
          if (do_stop) begin
            state <= ST_IDLE;
          end else if (do_pause) begin
            if (remain_out != '0) begin
              state   <= ST_RUN;
              run_out <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
`endif
        default: begin
          state   <= ST_IDLE;
          run_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/appliance_ctrl_hub.sv
// Multi-channel appliance control hub: valid/ready command port with a
// one-entry command buffer (accept, then apply next cycle), shared timer
// prescaler, command error reporting and N_DEV hub_channel instances.
// Optional feature macro: HUB_PAUSE_EN (pause/resume via control bit2).
// Ports: clk, rst (async, active-high); cmd_valid/cmd_ready handshake with
// cmd_dev/cmd_field/cmd_data; cmd_err pulse; temp_unit; packed per-channel
// temp_out, fan_out, remain_out, run_out, done_out.
module appliance_ctrl_hub
  import hub_pkg::*;
#(
  parameter int unsigned N_DEV    = 4,
  parameter int unsigned VAL_W    = 5,
  parameter int unsigned TEMP_MIN = 16,
  parameter int unsigned TEMP_MAX = 30,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [$clog2(N_DEV):0]    cmd_dev,
  input  logic [1:0]                cmd_field,
  input  logic [VAL_W-1:0]          cmd_data,
  output logic                      cmd_err,
  input  logic                      temp_unit,
  output logic [N_DEV*TEMP_W-1:0]   temp_out,
  output logic [N_DEV*2-1:0]        fan_out,
  output logic [N_DEV*VAL_W-1:0]    remain_out,
  output logic [N_DEV-1:0]          run_out,
  output logic [N_DEV-1:0]          done_out
);

  localparam int unsigned DEV_W = $clog2(N_DEV) + 1;
  localparam int unsigned DEV_N = 1 << DEV_W;
  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  logic [DEV_W-1:0] buf_dev;
  logic [1:0]       buf_field;
  logic [VAL_W-1:0] buf_data;
  logic [CNT_W-1:0] presc;
  logic             tick;
  logic             accept;
  logic             dev_bad;
  logic             start_req;
  logic [N_DEV-1:0] chan_en;
  logic [N_DEV-1:0] start_fail_c;
  logic [DEV_N-1:0] fail_vec;

  assign accept    = cmd_valid && cmd_ready;
  assign dev_bad   = (cmd_dev >= DEV_W'(N_DEV));
  assign start_req = (cmd_field == FIELD_CTRL) && cmd_data[CTRL_START] && !cmd_data[CTRL_STOP];
  assign tick      = (presc == CNT_W'(TICK_DIV - 1));
  // padded so any cmd_dev value indexes it directly
  assign fail_vec  = DEV_N'(start_fail_c);

  // Command buffer; cmd_ready low marks the apply cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      cmd_err   <= 1'b0;
      buf_dev   <= '0;
      buf_field <= 2'd0;
      buf_data  <= '0;
    end else begin
      // decided at accept so the pulse lands in the apply cycle
      cmd_err <= accept && (dev_bad || (start_req && fail_vec[cmd_dev]));
      if (accept) begin
        buf_dev   <= cmd_dev;
        buf_field <= cmd_field;
        buf_data  <= cmd_data;
        cmd_ready <= 1'b0;
      end else if (!cmd_ready) begin
        cmd_ready <= 1'b1;
      end
    end
  end

  // Free-running tick prescaler shared by all channels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N_DEV; i++) begin : g_ch
    // out-of-range buffered indices match no channel
    assign chan_en[i] = !cmd_ready && (buf_dev == DEV_W'(i));

    hub_channel #(
      .VAL_W    (VAL_W),
      .TEMP_MIN (TEMP_MIN),
      .TEMP_MAX (TEMP_MAX)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .cmd_en       (chan_en[i]),
      .cmd_field    (buf_field),
      .cmd_data     (buf_data),
      .temp_unit    (temp_unit),
      .temp_out     (temp_out[i*TEMP_W +: TEMP_W]),
      .fan_out      (fan_out[i*2 +: 2]),
      .remain_out   (remain_out[i*VAL_W +: VAL_W]),
      .run_out      (run_out[i]),
      .done_out     (done_out[i]),
      .start_fail_c (start_fail_c[i])
    );
  end

endmodule

// File: tb/tb_appliance_ctrl_hub.sv
// Self-checking bench for appliance_ctrl_hub: directed steps from the test
// plan followed by random commands, all checked every cycle against a
// per-channel behavioural model.
module tb_appliance_ctrl_hub;

  localparam int N_DEV    = 4;
  localparam int VAL_W    = 5;
  localparam int TEMP_MIN = 16;
  localparam int TEMP_MAX = 30;
  localparam int TICK_DIV = 4;
  localparam int DEV_W    = $clog2(N_DEV) + 1;

  logic                   clk;
  logic                   rst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [DEV_W-1:0]       cmd_dev;
  logic [1:0]             cmd_field;
  logic [VAL_W-1:0]       cmd_data;
  logic                   cmd_err;
  logic                   temp_unit;
  logic [N_DEV*7-1:0]     temp_out;
  logic [N_DEV*2-1:0]     fan_out;
  logic [N_DEV*VAL_W-1:0] remain_out;
  logic [N_DEV-1:0]       run_out;
  logic [N_DEV-1:0]       done_out;

  appliance_ctrl_hub #(
    .N_DEV(N_DEV), .VAL_W(VAL_W), .TEMP_MIN(TEMP_MIN), .TEMP_MAX(TEMP_MAX), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev),
    .cmd_field(cmd_field), .cmd_data(cmd_data), .cmd_err(cmd_err), .temp_unit(temp_unit),
    .temp_out(temp_out), .fan_out(fan_out), .remain_out(remain_out), .run_out(run_out),
    .done_out(done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int m_cnt;
  bit m_ready, m_pend, m_err;
  int p_dev, p_field, p_data;
  int m_sp[N_DEV], m_fan[N_DEV], m_rem[N_DEV], m_temp[N_DEV];
  bit m_run[N_DEV], m_done[N_DEV], m_pause[N_DEV];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_ready = 1; m_pend = 0; m_err = 0;
    p_dev = 0; p_field = 0; p_data = 0;
    for (int c = 0; c < N_DEV; c++) begin
      m_sp[c] = TEMP_MIN; m_fan[c] = 0; m_rem[c] = 0; m_temp[c] = TEMP_MIN;
      m_run[c] = 0; m_done[c] = 0; m_pause[c] = 0;
    end
  endtask

  task automatic model_apply(input int c);
    bit st, sp, pz;
    case (p_field)
      0: m_sp[c] = (p_data < TEMP_MIN) ? TEMP_MIN : ((p_data > TEMP_MAX) ? TEMP_MAX : p_data);
      1: m_fan[c] = p_data % 4;
      2: begin
        m_rem[c] = p_data;
        if (m_run[c] && p_data == 0) m_run[c] = 0;
      end
      default: begin
        st = p_data[0]; sp = p_data[1]; pz = p_data[2];
        if (sp) begin
          m_run[c] = 0; m_pause[c] = 0;
        end else if (m_run[c]) begin
`ifdef HUB_PAUSE_EN
          if (pz) begin m_run[c] = 0; m_pause[c] = 1; end
`endif
        end else if (m_pause[c]) begin
          if (pz) begin m_pause[c] = 0; m_run[c] = (m_rem[c] != 0); end
        end else if (st && m_rem[c] != 0) begin
          m_run[c] = 1;
        end
      end
    endcase
  endtask

  // Advance the model across one rising edge using the inputs now driven
  task automatic model_edge();
    bit tick, acc;
    int d;
    tick = (m_cnt == TICK_DIV - 1);
    acc  = cmd_valid && m_ready;
    for (int c = 0; c < N_DEV; c++) begin
      m_temp[c] = temp_unit ? (m_sp[c] * 9) / 5 + 32 : m_sp[c];
      m_done[c] = 0;
      if (m_pend && p_dev == c) begin
        model_apply(c);
      end else if (m_run[c] && tick) begin
        m_rem[c]--;
        if (m_rem[c] == 0) begin m_run[c] = 0; m_done[c] = 1; end
      end
    end
    d = int'(cmd_dev);
    m_err = 0;
    if (acc) begin
      if (d >= N_DEV) m_err = 1;
      else if (cmd_field == 2'd3 && cmd_data[0] && !cmd_data[1] &&
               !m_run[d] && !m_pause[d] && m_rem[d] == 0) m_err = 1;
    end
    if (acc) begin
      m_pend = 1; m_ready = 0;
      p_dev = d; p_field = int'(cmd_field); p_data = int'(cmd_data);
    end else if (m_pend) begin
      m_pend = 0; m_ready = 1;
    end
    m_cnt = tick ? 0 : m_cnt + 1;
  endtask

  task automatic check_all();
    logic [N_DEV*7-1:0]     et;
    logic [N_DEV*2-1:0]     ef;
    logic [N_DEV*VAL_W-1:0] er;
    logic [N_DEV-1:0]       eu, ed;
    for (int c = 0; c < N_DEV; c++) begin
      et[c*7 +: 7]         = 7'(m_temp[c]);
      ef[c*2 +: 2]         = 2'(m_fan[c]);
      er[c*VAL_W +: VAL_W] = VAL_W'(m_rem[c]);
      eu[c]                = m_run[c];
      ed[c]                = m_done[c];
    end
    chk("cmd_ready", 64'(cmd_ready), 64'(m_ready));
    chk("cmd_err", 64'(cmd_err), 64'(m_err));
    chk("temp_out", 64'(temp_out), 64'(et));
    chk("fan_out", 64'(fan_out), 64'(ef));
    chk("remain_out", 64'(remain_out), 64'(er));
    chk("run_out", 64'(run_out), 64'(eu));
    chk("done_out", 64'(done_out), 64'(ed));
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Present a command and hold it until the model says it was accepted
  task automatic send(input int dev, input int field, input int data, input bit hold);
    bit acc;
    acc = 0;
    cmd_valid = 1'b1;
    cmd_dev   = DEV_W'(dev);
    cmd_field = 2'(field);
    cmd_data  = VAL_W'(data);
    for (int k = 0; k < 8; k++) begin
      acc = m_ready;
      cycle();
      if (acc) break;
    end
    if (!acc) begin
      tests++; fails++;
      $error("FAIL send_timeout: observed not accepted expected accepted");
    end
    if (!hold) cmd_valid = 1'b0;
  endtask

  initial begin
    int r1;
    bit seen;
    bit acc;
    logic [N_DEV*7-1:0] t16;

    rst = 1'b1; cmd_valid = 1'b0; cmd_dev = '0; cmd_field = 2'd0; cmd_data = '0; temp_unit = 1'b0;
    model_reset();
    t16 = {N_DEV{7'd16}};
    @(posedge clk); #1;
    check_all();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_temp", 64'(temp_out), 64'(t16));
    #4 rst = 1'b0;

    // Setpoint clamp high in Fahrenheit, then clamp low in Celsius
    temp_unit = 1'b1;
    send(0, 0, 31, 0);
    cycle(); cycle();
    chk("sp31_f", 64'(temp_out[6:0]), 64'd86);
    temp_unit = 1'b0;
    send(0, 0, 3, 0);
    cycle(); cycle();
    chk("sp3_c", 64'(temp_out[6:0]), 64'd16);

    // Timer run to completion on ch2
    send(2, 2, 3, 0);
    send(2, 3, 1, 0);
    cycle();
    chk("ch2_run", 64'(run_out[2]), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (done_out[2]) begin seen = 1; break; end
    end
    chk("ch2_done_seen", 64'(seen), 64'd1);
    chk("ch2_remain0", 64'(remain_out[2*VAL_W +: VAL_W]), 64'd0);
    cycle();
    chk("ch2_done_1cyc", 64'(done_out[2]), 64'd0);
    chk("ch2_idle", 64'(run_out[2]), 64'd0);

    // Back-to-back commands with cmd_valid held high
    send(0, 1, 1, 1);
    send(1, 1, 2, 1);
    send(3, 1, 7, 1);
    send(1, 0, 20, 0);
    cycle();
    chk("b2b_fans", 64'(fan_out), 64'hC9);

    // Bad device index and start with a zero timer
    send(N_DEV, 0, 20, 0);
    chk("bad_dev_err", 64'(cmd_err), 64'd1);
    cycle();
    chk("bad_dev_err_clr", 64'(cmd_err), 64'd0);
    send(3, 3, 1, 0);
    chk("start0_err", 64'(cmd_err), 64'd1);
    cycle();
    chk("start0_idle", 64'(run_out[3]), 64'd0);

    // Timer load to a running ch0 coinciding with a tick while ch1 runs
    send(1, 2, 20, 0);
    send(1, 3, 1, 0);
    send(0, 2, 9, 0);
    send(0, 3, 1, 0);
    cycle();
    for (int k = 0; k < TICK_DIV + 1; k++) begin
      if (m_cnt == TICK_DIV - 2) break;
      cycle();
    end
    r1 = m_rem[1];
    send(0, 2, 7, 0);
    cycle();
    chk("coinc_ch0", 64'(remain_out[0 +: VAL_W]), 64'd7);
    chk("coinc_ch1", 64'(remain_out[VAL_W +: VAL_W]), 64'(r1 - 1));
    send(0, 3, 2, 0);
    cycle();

`ifdef HUB_PAUSE_EN
    send(1, 3, 4, 0);
    cycle();
    r1 = m_rem[1];
    for (int k = 0; k < 3 * TICK_DIV; k++) cycle();
    chk("pause_frozen", 64'(remain_out[VAL_W +: VAL_W]), 64'(r1));
    chk("pause_norun", 64'(run_out[1]), 64'd0);
    send(1, 3, 4, 0);
    for (int k = 0; k < 2 * TICK_DIV; k++) cycle();
    chk("resume_run", 64'(run_out[1]), 64'd1);
    chk("resume_dec", 64'(remain_out[VAL_W +: VAL_W] < VAL_W'(r1)), 64'd1);
`endif

    // Asynchronous reset while ch1 runs with remain 5
    send(1, 2, 5, 0);
    cycle();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_run", 64'(run_out), 64'd0);
    chk("arst_remain", 64'(remain_out), 64'd0);
    chk("arst_temp", 64'(temp_out), 64'(t16));
    #1 rst = 1'b0;
    cycle();
    chk("arst_ready", 64'(cmd_ready), 64'd1);

    // Random commands, protocol-compliant sender
    for (int i = 0; i < 800; i++) begin
      if (!cmd_valid && $urandom_range(0, 2) != 0) begin
        cmd_dev   = ($urandom_range(0, 9) == 0) ? DEV_W'(N_DEV) : DEV_W'($urandom_range(0, N_DEV - 1));
        cmd_field = 2'($urandom_range(0, 3));
        cmd_data  = (cmd_field == 2'd2) ? VAL_W'($urandom_range(0, 6)) :
                    (cmd_field == 2'd3) ? VAL_W'($urandom_range(0, 7)) : VAL_W'($urandom_range(0, 31));
        cmd_valid = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) temp_unit = ~temp_unit;
      acc = cmd_valid && m_ready;
      cycle();
      if (acc) cmd_valid = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
